// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type and default operand width for the Booth multiplier
package booth_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration with a widened add/sub and arithmetic right shift
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);
  logic [WIDTH:0] ax, mx, sum;
  assign ax = {a[WIDTH-1], a};
  assign mx = {m[WIDTH-1], m};
  assign sum = ({q[0], q_1} == 2'b01) ? ax + mx : ({q[0], q_1} == 2'b10) ? ax - mx : ax;
  assign a_next = sum[WIDTH:1];
  assign q_next = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];
endmodule

// File: rtl/booth_sequencer.sv
// booth_sequencer: sequential signed Booth multiplier with start/abort/ack handshake
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               ack,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a, q, m, a_n, q_n;
  logic q_1, q_1_n, accept, last;
  logic [CW-1:0] count;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .a(a), .q(q), .q_1(q_1), .m(m),
    .a_next(a_n), .q_next(q_n), .q_1_next(q_1_n)
  );
  assign busy = state == CALC;
  assign valid = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    accept = !abort && start && state != CALC;
    last = state == CALC && count == CW'(1);
    state_nxt = abort ? IDLE
              : accept ? CALC
              : last ? DONE
              : (state == DONE && ack) ? IDLE
              : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= '0;
      q <= '0;
      q_1 <= 1'b0;
      m <= '0;
      count <= '0;
      result <= '0;
    end else if (accept) begin
      a <= '0;
      q <= op_b;
      q_1 <= 1'b0;
      m <= op_a;
      count <= CW'(WIDTH);
    end else if (busy && !abort) begin
      a <= a_n;
      q <= q_n;
      q_1 <= q_1_n;
      count <= count - CW'(1);
      if (last) result <= {a_n, q_n};
    end
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: directed self-checking bench for booth_sequencer
module tb_booth_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, ack = 0;
  logic [7:0] op_a = 0, op_b = 0;
  logic busy, valid;
  logic [15:0] result;
  int total = 0, bad = 0;
  booth_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_a(op_a), .op_b(op_b),
    .ack(ack), .busy(busy), .valid(valid), .result(result)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [7:0] x, input logic [7:0] y);
    op_a = x;
    op_b = y;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 30) begin
      tick();
      lat++;
      total++;
      if (busy && valid) begin
        bad++;
        $display("FAIL excl: busy=%b valid=%b want not both", busy, valid);
      end
    end
  endtask
  task automatic test_reset();
    #1;
    total++;
    if ({busy, valid, result} !== 18'd0) begin
      bad++;
      $display("FAIL reset_async: busy=%b valid=%b result=%h want 0", busy, valid, result);
    end
    tick();
    tick();
    total++;
    if ({busy, valid, result} !== 18'd0) begin
      bad++;
      $display("FAIL reset_held: busy=%b valid=%b result=%h want 0", busy, valid, result);
    end
    rst = 0;
    tick();
  endtask
  task automatic test_basic();
    int lat;
    launch(8'd3, 8'hFC);
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL basic_busy: busy=%b valid=%b want 1 0", busy, valid);
    end
    wait_valid(lat);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    total++;
    if (result !== 16'hFFF4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got %h busy=%b want fff4 busy=0", result, busy);
    end
  endtask
  task automatic test_corners();
    int lat;
    launch(8'h80, 8'h80);
    wait_valid(lat);
    total++;
    if (lat !== 8 || result !== 16'h4000) begin
      bad++;
      $display("FAIL corner_min_min: lat=%0d result=%h want 8 4000", lat, result);
    end
    launch(8'h7F, 8'h80);
    wait_valid(lat);
    total++;
    if (lat !== 8 || result !== 16'hC080) begin
      bad++;
      $display("FAIL corner_max_min: lat=%0d result=%h want 8 c080", lat, result);
    end
  endtask
  task automatic test_start_ignored();
    int lat;
    launch(8'd5, 8'd7);
    tick();
    tick();
    op_a = 8'd9;
    op_b = 8'd9;
    start = 1;
    tick();
    start = 0;
    op_a = 8'd0;
    op_b = 8'd0;
    wait_valid(lat);
    total++;
    if (lat + 3 !== 8 || result !== 16'h0023) begin
      bad++;
      $display("FAIL start_ignored: lat=%0d result=%h want 8 0023", lat + 3, result);
    end
  endtask
  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (valid !== 1'b1 || result !== 16'h0023) begin
        bad++;
        $display("FAIL hold_%0d: valid=%b result=%h want 1 0023", i, valid, result);
      end
    end
    ack = 1;
    tick();
    ack = 0;
    total++;
    if ({busy, valid} !== 2'b00 || result !== 16'h0023) begin
      bad++;
      $display("FAIL ack_clear: busy=%b valid=%b result=%h want 0 0 0023", busy, valid, result);
    end
    ack = 1;
    tick();
    ack = 0;
    total++;
    if ({busy, valid} !== 2'b00 || result !== 16'h0023) begin
      bad++;
      $display("FAIL ack_idle: busy=%b valid=%b result=%h want 0 0 0023", busy, valid, result);
    end
  endtask
  task automatic test_ack_in_calc();
    int lat;
    launch(8'd2, 8'd3);
    ack = 1;
    tick();
    ack = 0;
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL ack_calc: busy=%b valid=%b want 1 0", busy, valid);
    end
    wait_valid(lat);
    total++;
    if (lat + 1 !== 8 || result !== 16'h0006) begin
      bad++;
      $display("FAIL ack_calc_result: lat=%0d result=%h want 8 0006", lat + 1, result);
    end
  endtask
  task automatic test_abort();
    int lat;
    launch(8'd7, 8'd7);
    tick();
    tick();
    tick();
    abort = 1;
    start = 1;
    ack = 1;
    tick();
    abort = 0;
    start = 0;
    ack = 0;
    total++;
    if ({busy, valid} !== 2'b00 || result !== 16'h0006) begin
      bad++;
      $display("FAIL abort: busy=%b valid=%b result=%h want 0 0 0006", busy, valid, result);
    end
    tick();
    total++;
    if ({busy, valid} !== 2'b00) begin
      bad++;
      $display("FAIL abort_stay: busy=%b valid=%b want 0 0", busy, valid);
    end
    launch(8'hFD, 8'd5);
    wait_valid(lat);
    total++;
    if (lat !== 8 || result !== 16'hFFF1) begin
      bad++;
      $display("FAIL after_abort: lat=%0d result=%h want 8 fff1", lat, result);
    end
  endtask
  task automatic test_start_ack();
    int lat;
    op_a = 8'd0;
    op_b = 8'd55;
    start = 1;
    ack = 1;
    tick();
    start = 0;
    ack = 0;
    total++;
    if ({busy, valid} !== 2'b10) begin
      bad++;
      $display("FAIL start_ack_accept: busy=%b valid=%b want 1 0", busy, valid);
    end
    wait_valid(lat);
    total++;
    if (lat !== 8 || result !== 16'h0000) begin
      bad++;
      $display("FAIL start_ack_result: lat=%0d result=%h want 8 0000", lat, result);
    end
  endtask
  task automatic test_rst_mid();
    int lat;
    launch(8'hF9, 8'hF7);
    tick();
    tick();
    tick();
    rst = 1;
    #2;
    total++;
    if ({busy, valid, result} !== 18'd0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b valid=%b result=%h want 0 0 0000", busy, valid, result);
    end
    tick();
    rst = 0;
    tick();
    launch(8'd12, 8'hF5);
    wait_valid(lat);
    total++;
    if (lat !== 8 || result !== 16'hFF7C) begin
      bad++;
      $display("FAIL after_rst: lat=%0d result=%h want 8 ff7c", lat, result);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_hold();
    test_ack_in_calc();
    test_abort();
    test_start_ack();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_sequencer.md
BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; result width is 2*WIDTH.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to multiply op_a by op_b; sampled on the rising edge.
REQ-005 abort  input  1  synchronous cancel of any operation in progress.
REQ-006 op_a  input  WIDTH  multiplicand, two's complement, captured at accept.
REQ-007 op_b  input  WIDTH  multiplier, two's complement, captured at accept.
REQ-008 ack  input  1  consumer acknowledge of the result.
REQ-009 busy  output  1  high while an iteration sequence is running.
REQ-010 valid  output  1  result holds a completed product.
REQ-011 result  output  2*WIDTH  signed product, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE, defined in the shared package.
REQ-013 Accept: in IDLE or DONE with start=1 and abort=0, the block SHALL load M=op_a, Q=op_b, A=0, Q_1=0 and count=WIDTH, SHALL set busy=1 and valid=0, and SHALL enter CALC on the same edge.
REQ-014 In CALC, each cycle SHALL perform one radix-2 Booth step: {Q0,Q_1}=01 gives A+M, 10 gives A-M, 00/11 leave A unchanged; then {A,Q,Q_1} SHALL be arithmetic-shifted right by one, and count SHALL decrement.
REQ-015 Add/subtract SHALL be computed at WIDTH+1 bits so that M=-2^(WIDTH-1) is correct; A keeps WIDTH bits after the shift.
REQ-016 On the step where count reaches 0, the block SHALL register result={A,Q} (post-shift), set valid=1 and busy=0, and enter DONE.
REQ-017 Latency: valid SHALL rise exactly WIDTH clock edges after the accepting edge (8 for the default).
REQ-018 start while in CALC SHALL be ignored, with no effect on operands or count.
REQ-019 In DONE, valid and result SHALL hold until ack=1; ack SHALL clear valid on the next edge and return the FSM to IDLE, while result keeps its value.
REQ-020 start and ack together in DONE: start SHALL win (a new accept per REQ-013).
REQ-021 ack in IDLE or CALC SHALL be ignored.
REQ-022 abort=1 in any state SHALL force IDLE, busy=0 and valid=0 on the next edge, leaving result unchanged; abort SHALL win over start and ack.
REQ-023 The outputs busy and valid SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, valid=0, result=0, and A, Q, Q_1, M and count to 0, independent of clk.
REQ-025 Reset asserted mid-CALC SHALL discard the operation; the first accept after reset release SHALL follow REQ-013 normally.

Structure
REQ-026 A shared package booth_pkg SHALL hold the state enum and the default-WIDTH constant.
REQ-027 The Booth step SHALL be one combinational sub-module, booth_step (inputs A, Q, Q_1, M; outputs next A, Q, Q_1).
REQ-028 The FSM, counter and registers SHALL reside in booth_sequencer.

Verification
REQ-029 op_a=3, op_b=-4, start pulse -> busy for 8 cycles, then valid=1 with result=16'hFFF4 (-12).
REQ-030 op_a=-128, op_b=-128 -> result=16'h4000; op_a=127, op_b=-128 -> result=16'hC080.
REQ-031 Send start again at cycle 3 of CALC with different operands -> ignored; the original product is delivered at cycle 8.
REQ-032 Scenario: valid held with no ack for 20 cycles, then ack -> valid and result stable throughout; valid=0 after one edge; result retained.
REQ-033 Scenario: start+ack in DONE with op_a=0, op_b=55 -> new accept; result=0 after 8 cycles.
REQ-034 Scenario: abort at CALC cycle 4, and separately rst pulse mid-CALC -> IDLE with busy=0 and valid=0; for the rst case, all outputs are 0; the next operation completes correctly.
